array_bank_access_adapter: RTL

- Per-bank front-end between the array mux and one mruCache bank; replaces the fixed 32-bit shift/mask glue.
- Generalised in data width, supports sign-extended sub-word reads, and splits word-crossing (misaligned) accesses into two cache accesses. Read data from a split is merged before it is returned.
- Tracks outstanding reads in a bounded FIFO with real backpressure; overflow is impossible by construction.
- Instantiated once per bank inside the array bank wrapper.

---
 rtl/array_bank_access_adapter_pkg.sv | 50 +++++
 rtl/array_bank_access_adapter_if.sv | 17 +
 rtl/array_bank_access_adapter_trk_fifo.sv | 44 ++++
 rtl/array_bank_access_adapter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/array_bank_access_adapter_pkg.sv
// Shared cache-adapter definitions: size encodings, tracking entry and lane helpers.
// Helpers work at the 64-bit maximum width; callers slice down to DW.
package xcache_param_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {ST_IDLE, ST_SPLIT2} acc_st_e;

    typedef struct packed {
        logic [2:0] off;
        logic [1:0] size;
        logic       sgn;
        logic       split;
    } trk_ent_t;

    // Byte enables over two consecutive words: [WB-1:0] is lo, [2WB-1:WB] is hi.
    function automatic logic [15:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
        logic [15:0] b;
        case (size)
            SZ_B:    b = 16'h0001;
            SZ_H:    b = 16'h0003;
            SZ_W:    b = 16'h000F;
            default: b = 16'h00FF;
        endcase
        return b << off;
    endfunction

    function automatic logic [127:0] lane_shift(input logic [63:0] din, input logic [2:0] off);
        return {64'b0, din} << {off, 3'b000};
    endfunction

    function automatic logic [63:0] rd_extend(input logic [127:0] w, input logic [2:0] off,
                                              input logic [1:0] size, input logic sgn);
        logic [127:0] s;
        logic [63:0]  m;
        logic         sb;
        s = w >> {off, 3'b000};
        case (size)
            SZ_B:    begin m = 64'h0000_0000_0000_00FF; sb = s[7];  end
            SZ_H:    begin m = 64'h0000_0000_0000_FFFF; sb = s[15]; end
            SZ_W:    begin m = 64'h0000_0000_FFFF_FFFF; sb = s[31]; end
            default: begin m = '1;                      sb = s[63]; end
        endcase
        return (s[63:0] & m) | ({64{sgn & sb}} & ~m);
    endfunction

endpackage

// File: rtl/array_bank_access_adapter_if.sv
// User-side request/response bus of the bank access adapter.
interface array_bank_access_adapter_if #(parameter int DW = 32, parameter int AW = 16);
    logic          user_ready;
    logic          user_re;
    logic          user_we;
    logic [1:0]    user_size;
    logic          user_signed;
    logic [AW-1:0] user_adr;
    logic [DW-1:0] user_din;
    logic [DW-1:0] user_dout;
    logic          user_dout_vld;

    modport master (input user_ready, user_dout, user_dout_vld,
                    output user_re, user_we, user_size, user_signed, user_adr, user_din);
    modport slave  (output user_ready, user_dout, user_dout_vld,
                    input user_re, user_we, user_size, user_signed, user_adr, user_din);
endinterface

// File: rtl/array_bank_access_adapter_trk_fifo.sv
// Sync FIFO holding in-flight read descriptors; push when full / pop when empty are ignored.
module array_trk_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/array_bank_access_adapter.sv
// Per-bank front-end to one mruCache bank: lane positioning, sub-word extend,
// split of word-crossing accesses and in-order read tracking.
module array_bank_access_adapter
    import xcache_param_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 16,
    parameter int OUTSTANDING = 4,
    parameter int SPLIT_EN    = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    array_bank_access_adapter_if.slave    u,
    output logic [$clog2(OUTSTANDING):0]  outstanding,
    output logic                          misalign_err,
    input  logic                          c_ready,
    output logic                          c_re,
    output logic                          c_we,
    output logic [DW/8-1:0]               c_we_mask,
    output logic [AW-1:0]                 c_adr,
    output logic [DW-1:0]                 c_wdat,
    input  logic [DW-1:0]                 c_rdat,
    input  logic                          c_rdat_vld
);
    localparam int WB = DW / 8;
    localparam int OW = $clog2(WB);
    localparam int TW = $bits(trk_ent_t);

    acc_st_e       st, st_nxt;
    logic [2:0]    off;
    logic [15:0]   m2;
    logic [127:0]  sh;
    logic [AW-1:0] wadr;
    logic          mis, rdy, acc, do_split, push, pop, full, empty, beat;
    trk_ent_t      ent, head;
    logic [AW-1:0] h_adr;
    logic [WB-1:0] h_mask;
    logic [DW-1:0] h_wdat, lo_buf;
    logic          h_re, h_we;
    logic [2*DW-1:0] w2;
    logic [63:0]   rx;

    assign off      = 3'(u.user_adr[OW-1:0]);
    assign m2       = lane_mask(off, u.user_size);
    assign sh       = lane_shift(64'(u.user_din), off);
    assign wadr     = u.user_adr & ~AW'(WB - 1);
    assign mis      = |m2[2*WB-1:WB];
    assign do_split = mis & (SPLIT_EN != 0);

    assign rdy          = (st == ST_IDLE) & c_ready & ~full;
    assign u.user_ready = rdy;
    assign acc          = rdy & (u.user_re | u.user_we);
    assign push         = acc & u.user_re & ~u.user_we;
    assign ent          = '{off: off, size: u.user_size, sgn: u.user_signed, split: do_split};

    always_comb begin
        st_nxt    = st;
        c_re      = 1'b0;
        c_we      = 1'b0;
        c_adr     = wadr;
        c_we_mask = m2[WB-1:0];
        c_wdat    = sh[DW-1:0];
        case (st)
            ST_IDLE: begin
                // Request is shown to the cache only when it can be tracked.
                c_we = u.user_we & ~full;
                c_re = u.user_re & ~u.user_we & ~full;
                if (acc && do_split) st_nxt = ST_SPLIT2;
            end
            ST_SPLIT2: begin
                c_re      = h_re;
                c_we      = h_we;
                c_adr     = h_adr;
                c_we_mask = h_mask;
                c_wdat    = h_wdat;
                if (c_ready) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st           <= ST_IDLE;
            h_adr        <= '0;
            h_mask       <= '0;
            h_wdat       <= '0;
            h_re         <= 1'b0;
            h_we         <= 1'b0;
            misalign_err <= 1'b0;
            beat         <= 1'b0;
            lo_buf       <= '0;
        end else begin
            st <= st_nxt;
            if (acc && do_split) begin
                h_adr  <= wadr + AW'(WB);
                h_mask <= m2[2*WB-1:WB];
                h_wdat <= sh[2*DW-1:DW];
                h_re   <= u.user_re & ~u.user_we;
                h_we   <= u.user_we;
            end
            if (acc && mis && SPLIT_EN == 0) misalign_err <= 1'b1;
            if (c_rdat_vld && !empty) begin
                if (head.split && !beat) begin
                    lo_buf <= c_rdat;
                    beat   <= 1'b1;
                end else begin
                    beat   <= 1'b0;
                end
            end
        end
    end

    array_trk_fifo #(.W(TW), .DEPTH(OUTSTANDING)) u_trk (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (ent),
        .dout  (head),
        .count (outstanding),
        .full  (full),
        .empty (empty)
    );

    // A split entry retires on its second beat; the first only fills lo_buf.
    assign pop             = c_rdat_vld & ~empty & (~head.split | beat);
    assign w2              = head.split ? {c_rdat, lo_buf} : {{DW{1'b0}}, c_rdat};
    assign rx              = rd_extend(128'(w2), head.off, head.size, head.sgn);
    assign u.user_dout     = rx[DW-1:0];
    assign u.user_dout_vld = pop;

    a_no_orphan_rdat: assert property (@(posedge clk) disable iff (!rstn) c_rdat_vld |-> !empty);
endmodule
